// File: rtl/gray_tracker_if.sv
// gray_tracker_if
// Bundles the signals between a Gray-code step counter consumer (the
// tracker) and whoever drives it.
//   GrayIn      3-bit Gray code from the upstream counter
//   OverflowIn  sticky overflow flag from the upstream counter
//   Clear       synchronous re-sync request
//   Bin         binary equivalent of the last accepted code
//   Laps        completed 7->0 wraps since the last re-sync
//   Locked      tracker is following the counter
//   StepErr     sticky violation flag
//   ErrCount    saturating violation count
// Modports: master drives the counter side, slave is the tracker.
interface gray_tracker_if #(
   parameter int LAP_W = 8
);
   logic [2:0]       GrayIn;
   logic             OverflowIn;
   logic             Clear;
   logic [2:0]       Bin;
   logic [LAP_W-1:0] Laps;
   logic             Locked;
   logic             StepErr;
   logic [7:0]       ErrCount;

   modport master (
      output GrayIn, OverflowIn, Clear,
      input  Bin, Laps, Locked, StepErr, ErrCount
   );

   modport slave (
      input  GrayIn, OverflowIn, Clear,
      output Bin, Laps, Locked, StepErr, ErrCount
   );
endinterface

// File: rtl/gray_tracker.sv
// gray_tracker
// Samples a 3-bit Gray-code step counter every cycle, converts it to
// binary, checks that every change is a single forward step consistent
// with the counter's overflow flag, counts completed laps and flags
// violations.
// Ports:
//   Clk    clock, rising edge
//   Reset  synchronous, active-high
//   bus    gray_tracker_if.slave (GrayIn/OverflowIn/Clear in,
//          Bin/Laps/Locked/StepErr/ErrCount out)
// Build option: define GRAY_TRACKER_ERRCNT_EN to implement the saturating
// ErrCount register; otherwise ErrCount reads as zero.
//
// state | meaning
// SYNC  | capture current code and overflow flag as the reference
// TRACK | follow the counter, accept single forward steps
// FAULT | violation seen, outputs frozen until Clear or Reset
module gray_tracker #(
   parameter int LAP_W = 8
) (
   input  logic           Clk,
   input  logic           Reset,
   gray_tracker_if.slave  bus
);

   typedef enum logic [1:0] {SYNC, TRACK, FAULT} state_t;

   state_t           state;
   logic [2:0]       prev_bin;
   logic             prev_ovf;
   logic [2:0]       bin_q;
   logic [LAP_W-1:0] laps_q;
   logic             locked_q;
   logic             step_err_q;

   logic [2:0]       cur_bin;
   logic             same;
   logic             fwd_step;
   logic             wrap;
   logic             ovf_rise;
   logic             ovf_drop;
   logic             violation;

   always_comb begin
      cur_bin  = {bus.GrayIn[2], bus.GrayIn[2] ^ bus.GrayIn[1], ^bus.GrayIn};
      same     = (cur_bin == prev_bin);
      fwd_step = (cur_bin == 3'(prev_bin + 3'd1));
      wrap     = fwd_step && (prev_bin == 3'd7);
      ovf_rise = !prev_ovf && bus.OverflowIn;
      ovf_drop = prev_ovf && !bus.OverflowIn;
      // An overflow drop means the counter was reset upstream, so that
      // cycle's code is not judged at all. Once overflow is already set,
      // wraps are no longer cross-checked against it.
      violation = (state == TRACK) && !ovf_drop &&
                  ((!same && !fwd_step) ||
                   (ovf_rise && !wrap) ||
                   (wrap && !prev_ovf && !bus.OverflowIn));
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state      <= SYNC;
         prev_bin   <= 3'd0;
         prev_ovf   <= 1'b0;
         bin_q      <= 3'd0;
         laps_q     <= '0;
         locked_q   <= 1'b0;
         step_err_q <= 1'b0;
      end else if (bus.Clear) begin
         // Clear wins over any same-cycle step or violation.
         state      <= SYNC;
         laps_q     <= '0;
         locked_q   <= 1'b0;
         step_err_q <= 1'b0;
         if (state != FAULT) prev_ovf <= bus.OverflowIn;
      end else begin
         case (state)
            SYNC: begin
               prev_bin <= cur_bin;
               bin_q    <= cur_bin;
               prev_ovf <= bus.OverflowIn;
               laps_q   <= '0;
               locked_q <= 1'b1;
               state    <= TRACK;
            end
            TRACK: begin
               prev_ovf <= bus.OverflowIn;
               if (ovf_drop) begin
                  locked_q <= 1'b0;
                  state    <= SYNC;
               end else if (violation) begin
                  step_err_q <= 1'b1;
                  locked_q   <= 1'b0;
                  state      <= FAULT;
               end else if (fwd_step) begin
                  prev_bin <= cur_bin;
                  bin_q    <= cur_bin;
                  if (wrap) laps_q <= laps_q + LAP_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.Bin     = bin_q;
   assign bus.Laps    = laps_q;
   assign bus.Locked  = locked_q;
   assign bus.StepErr = step_err_q;

`ifdef GRAY_TRACKER_ERRCNT_EN
   logic [7:0] err_cnt;

   always_ff @(posedge Clk) begin
      if (Reset)
         err_cnt <= 8'd0;
      else if (violation && !bus.Clear && (err_cnt != 8'hFF))
         err_cnt <= err_cnt + 8'd1;
   end

   assign bus.ErrCount = err_cnt;
`else
   assign bus.ErrCount = 8'd0;
`endif

endmodule

// File: tb/tb_gray_tracker.sv
module tb_gray_tracker;

   localparam int LAP_W = 8;

   logic Clk;
   logic Reset;
   int   n_assert;
   int   n_fail;

   logic [2:0] gc [8];

   gray_tracker_if #(.LAP_W(LAP_W)) bus ();

   gray_tracker #(.LAP_W(LAP_W)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus.slave)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   function automatic int exp_err(input int n);
`ifdef GRAY_TRACKER_ERRCNT_EN
      return (n > 255) ? 255 : n;
`else
      return 0;
`endif
   endfunction

   task automatic step(input logic [2:0] g, input logic ovf, input logic clr);
      bus.GrayIn     = g;
      bus.OverflowIn = ovf;
      bus.Clear      = clr;
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      gc[0] = 3'b000; gc[1] = 3'b001; gc[2] = 3'b011; gc[3] = 3'b010;
      gc[4] = 3'b110; gc[5] = 3'b111; gc[6] = 3'b101; gc[7] = 3'b100;

      // reset
      Reset = 1'b1;
      step(gc[0], 1'b0, 1'b0);
      step(gc[0], 1'b0, 1'b0);
      chk("rst_bin", bus.Bin, 0);
      chk("rst_laps", bus.Laps, 0);
      chk("rst_locked", bus.Locked, 0);
      chk("rst_steperr", bus.StepErr, 0);
      chk("rst_errcnt", bus.ErrCount, 0);

      // capture then one legal lap, overflow rising on the wrap
      Reset = 1'b0;
      step(gc[0], 1'b0, 1'b0);
      chk("sync_locked", bus.Locked, 1);
      chk("sync_bin", bus.Bin, 0);
      for (int b = 1; b < 8; b++) begin
         step(gc[b], 1'b0, 1'b0);
         chk("lap_bin", bus.Bin, b);
      end
      step(gc[0], 1'b1, 1'b0);
      chk("wrap_bin", bus.Bin, 0);
      chk("wrap_laps", bus.Laps, 1);
      chk("wrap_locked", bus.Locked, 1);
      chk("wrap_steperr", bus.StepErr, 0);

      // hold
      for (int i = 0; i < 10; i++) step(gc[0], 1'b1, 1'b0);
      chk("hold_bin", bus.Bin, 0);
      chk("hold_steperr", bus.StepErr, 0);
      chk("hold_laps", bus.Laps, 1);

      // upstream reset: overflow drops
      step(gc[0], 1'b0, 1'b0);
      chk("ureset_locked", bus.Locked, 0);
      chk("ureset_steperr", bus.StepErr, 0);
      step(gc[0], 1'b0, 1'b0);
      chk("ureset_laps", bus.Laps, 0);
      chk("ureset_relock", bus.Locked, 1);

      // 256 laps wrap the lap counter
      for (int lap = 1; lap <= 256; lap++) begin
         for (int b = 1; b < 8; b++) step(gc[b], (lap > 1), 1'b0);
         step(gc[0], 1'b1, 1'b0);
         if (lap == 1)   chk("laps_1", bus.Laps, 1);
         if (lap == 255) chk("laps_255", bus.Laps, 255);
         if (lap == 256) chk("laps_256", bus.Laps, 0);
      end
      chk("laps_steperr", bus.StepErr, 0);

      // one more lap, then a skip 011 -> 110
      for (int b = 1; b < 8; b++) step(gc[b], 1'b1, 1'b0);
      step(gc[0], 1'b1, 1'b0);
      step(gc[1], 1'b1, 1'b0);
      step(gc[2], 1'b1, 1'b0);
      step(3'b110, 1'b1, 1'b0);
      chk("skip_steperr", bus.StepErr, 1);
      chk("skip_locked", bus.Locked, 0);
      chk("skip_bin", bus.Bin, 2);
      chk("skip_laps", bus.Laps, 1);
      chk("skip_errcnt", bus.ErrCount, exp_err(1));
      step(gc[3], 1'b1, 1'b0);
      step(gc[5], 1'b0, 1'b0);
      chk("frozen_bin", bus.Bin, 2);
      chk("frozen_steperr", bus.StepErr, 1);
      chk("frozen_laps", bus.Laps, 1);
      chk("frozen_errcnt", bus.ErrCount, exp_err(1));

      // clear out of fault
      step(gc[3], 1'b0, 1'b1);
      chk("clr_steperr", bus.StepErr, 0);
      chk("clr_laps", bus.Laps, 0);
      chk("clr_locked", bus.Locked, 0);
      chk("clr_errcnt", bus.ErrCount, exp_err(1));
      step(gc[3], 1'b0, 1'b0);
      chk("clr_relock", bus.Locked, 1);
      chk("clr_bin", bus.Bin, 3);

      // clear beats a same-cycle violation
      step(gc[6], 1'b0, 1'b1);
      chk("clrpri_steperr", bus.StepErr, 0);
      chk("clrpri_errcnt", bus.ErrCount, exp_err(1));
      step(gc[3], 1'b0, 1'b0);
      chk("clrpri_bin", bus.Bin, 3);

      // clear beats a same-cycle legal step
      step(gc[4], 1'b0, 1'b1);
      chk("clrstep_bin", bus.Bin, 3);
      step(gc[3], 1'b0, 1'b0);
      chk("clrstep_locked", bus.Locked, 1);

      // overflow rises without a wrap
      step(gc[3], 1'b1, 1'b0);
      chk("ovfrise_steperr", bus.StepErr, 1);
      chk("ovfrise_bin", bus.Bin, 3);
      chk("ovfrise_errcnt", bus.ErrCount, exp_err(2));

      // wrap with overflow held low
      step(gc[0], 1'b0, 1'b1);
      step(gc[0], 1'b0, 1'b0);
      chk("nowrap_sync_bin", bus.Bin, 0);
      for (int b = 1; b < 8; b++) step(gc[b], 1'b0, 1'b0);
      chk("nowrap_pre_bin", bus.Bin, 7);
      step(gc[0], 1'b0, 1'b0);
      chk("nowrap_steperr", bus.StepErr, 1);
      chk("nowrap_bin", bus.Bin, 7);
      chk("nowrap_laps", bus.Laps, 0);
      chk("nowrap_errcnt", bus.ErrCount, exp_err(3));

      // 300 more violations, each cleared
      for (int i = 1; i <= 300; i++) begin
         step(gc[0], 1'b0, 1'b1);
         step(gc[0], 1'b0, 1'b0);
         step(gc[2], 1'b0, 1'b0);
         if (i == 100) chk("sat_mid_errcnt", bus.ErrCount, exp_err(103));
      end
      chk("sat_errcnt", bus.ErrCount, exp_err(303));
      chk("sat_steperr", bus.StepErr, 1);

      // reset mid-operation
      Reset = 1'b1;
      step(gc[2], 1'b0, 1'b0);
      chk("rst2_errcnt", bus.ErrCount, 0);
      chk("rst2_steperr", bus.StepErr, 0);
      chk("rst2_bin", bus.Bin, 0);
      chk("rst2_locked", bus.Locked, 0);
      Reset = 1'b0;
      step(gc[1], 1'b0, 1'b0);
      chk("rst2_relock", bus.Locked, 1);
      chk("rst2_capbin", bus.Bin, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/gray_tracker.md
# gray_tracker

Downstream consumer of the 3-bit Gray-code step counter. It samples the counter's code and overflow flag every cycle and converts the code to binary. It checks that every change is a legal single forward step and accumulates completed laps. It flags and counts protocol violations so that upstream counter faults are visible to the system.

## Interface
Parameters:
- LAP_W, 8, width of the lap counter (wraps modulo 2^LAP_W).

Ports:
- Clk  input  1  clock, all logic on rising edge.
- Reset  input  1  synchronous, active-high.
- GrayIn  input  3  Gray code from the upstream counter.
- OverflowIn  input  1  sticky overflow flag from the upstream counter.
- Clear  input  1  synchronous re-sync request; clears Laps and StepErr.
- Bin  output  3  binary equivalent of the last accepted code.
- Laps  output  LAP_W  completed 7->0 wraps since the last SYNC.
- Locked  output  1  high while in TRACK.
- StepErr  output  1  sticky violation flag; high while in FAULT.
- ErrCount  output  8  saturating violation count.

## Operation
- Gray->binary: b2=g2, b1=g2^g1, b0=g2^g1^g0. Legal sequence is 000,001,011,010,110,111,101,100, which is binary 0..7.
- Internal state: prev_bin (3b), prev_ovf (1b), FSM state.
- FSM states:
  - SYNC: load prev_bin=Bin=bin(GrayIn), prev_ovf=OverflowIn, Laps=0 -> TRACK.
  - TRACK:
    - bin(GrayIn)==prev_bin: hold.
    - bin==prev_bin+1 (mod 8): accept the step, update Bin and prev_bin.
    - Any other change is a violation -> FAULT.
  - FAULT: outputs frozen, GrayIn ignored; leaves only on Clear or Reset.
- Overflow cross-check, TRACK only:
  - OverflowIn 0->1 with an accepted 7->0 step: legal.
  - OverflowIn 0->1 without a 7->0 step: violation.
  - Accepted 7->0 step while OverflowIn stays 0: violation.
  - 7->0 step with prev_ovf=1: legal, no overflow check applied.
  - OverflowIn 1->0: treated as an upstream reset. Go to SYNC with no error; that cycle's code is not checked.
- Accepted 7->0 step: Laps+1, modulo 2^LAP_W.
- Violation: StepErr=1, ErrCount+1 saturating at 255, Bin/Laps unchanged, -> FAULT.
- Clear, any state: -> SYNC. StepErr=0, Laps=0. ErrCount is kept.
- Clear has priority over a same-cycle violation and over same-cycle step acceptance.
- prev_ovf updates every cycle outside FAULT.

## Timing
- Reset values: state=SYNC, Bin=0, Laps=0, Locked=0, StepErr=0, ErrCount=0, prev_bin=0, prev_ovf=0.
- Reset mid-operation discards all state, including ErrCount.
- Latency: GrayIn/OverflowIn present before edge k -> Bin/Laps/StepErr/Locked updated at edge k (1 cycle, registered outputs).
- After Reset or Clear deasserts:
  - first edge: SYNC capture;
  - Locked=1 from the next edge;
  - the first step check applies to the sample at the edge after that.
- No handshake. A step is accepted on any cycle. GrayIn may change at most one legal step per cycle.
- Laps wraps from 2^LAP_W-1 to 0 silently.

## Configuration
- GRAY_TRACKER_ERRCNT_EN defined: ErrCount is implemented as specified.
- GRAY_TRACKER_ERRCNT_EN undefined: no counter register; ErrCount is tied to 8'd0.
- All other behaviour, including StepErr and FAULT, is identical with or without the macro.

## Test plan
- Reset, then drive the legal sequence 000..100 with OverflowIn rising on the 100->000 step -> Bin steps 0..7,0; Laps=1; Locked=1; StepErr=0.
- Hold GrayIn constant for 10 cycles in TRACK -> Bin unchanged; no error.
- In TRACK at 011, drive 110 (skip) -> StepErr=1 next edge, ErrCount=1, Locked=0. Later GrayIn changes -> outputs frozen. Clear -> StepErr=0, Laps=0, ErrCount stays 1, Locked=1 two edges later.
- OverflowIn 0->1 while GrayIn stays at 010 -> violation, ErrCount+1. Separately, a 100->000 wrap with OverflowIn held 0 from reset -> violation.
- After the first wrap, drop OverflowIn to 0 and GrayIn to 000 (upstream reset) -> SYNC, no error, Laps=0. Then 256 further laps with LAP_W=8 -> Laps returns to 0.
- Force 300 violations, each followed by Clear -> ErrCount saturates at 255 with the macro defined; ErrCount=0 throughout with it undefined.
